// File: rtl/mem_stage_pkg.sv
// Shared control-field layout, size encodings and FSM states for the MEM-stage data memory.
package mem_stage_pkg;

    localparam int READ_BIT     = 5;
    localparam int WRITE_BIT    = 4;
    localparam int UNSIGNED_BIT = 3;
    localparam int SIZE_MSB     = 2;
    localparam int SIZE_LSB     = 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_FULL = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        DBG_WAIT = 2'd2
    } dmem_state_e;

    // Number of byte-lane address bits in one NB_DATA-wide word.
    function automatic int lane_bits(input int nb_data);
        return $clog2(nb_data / 8);
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port byte-enabled RAM with a parametrised read pipeline.
module dmem_bram #(
    parameter int NB_DATA    = 32,
    parameter int NB_WADDR   = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic [NB_WADDR-1:0]     addr_i,
    input  logic [NB_DATA/8-1:0]    we_i,
    input  logic [NB_DATA-1:0]      wdata_i,
    output logic [NB_DATA-1:0]      rdata_o
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int DEPTH    = 1 << NB_WADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB_BYTES; b++) begin
            if (we_i[b]) begin
                mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // The last latency stage is the requester's own output register, so only
    // RD_LATENCY-1 stages live here; with latency 1 the array is read directly.
    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign rdata_o = mem[addr_i];
        end else begin : g_pipe
            logic [NB_DATA-1:0] stage_q [RD_LATENCY-1];

            always_ff @(posedge clk_i) begin
                stage_q[0] <= mem[addr_i];
                for (int s = 1; s < RD_LATENCY - 1; s++) begin
                    stage_q[s] <= stage_q[s-1];
                end
            end

            assign rdata_o = stage_q[RD_LATENCY-2];
        end
    endgenerate

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte-enabled stores, aligned/extended loads with a
// load stall, and a debug word port arbitrated onto the same array.
module mem_stage_dmem
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int ADDRWIDTH   = 10,
    parameter int NB_MEM_CTRL = 6,
    parameter int RD_LATENCY  = 1,
    localparam int LSB        = lane_bits(NB_DATA),
    localparam int NB_WADDR   = ADDRWIDTH - LSB
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable_mem,
    input  logic [NB_MEM_CTRL-1:0] i_MEM_control,
    input  logic [ADDRWIDTH-1:0]   i_alu_result,
    input  logic [NB_DATA-1:0]     i_data_write,
    output logic [NB_DATA-1:0]     o_mem_data,
    output logic                   o_rd_valid,
    output logic                   o_stall,
    output logic                   o_misaligned,
    output logic                   o_bit_sucio,
    input  logic                   i_clr_sucio,
    input  logic                   i_ctrl_addr_debug_mem,
    input  logic                   i_ctrl_wr_debug_mem,
    input  logic [NB_WADDR-1:0]    i_addr_mem_debug_unit,
    input  logic [NB_DATA-1:0]     i_data_debug_unit,
    output logic [NB_DATA-1:0]     o_data_mem_debug_unit,
    output logic                   o_dbg_valid
);

    localparam int         NB_BYTES = NB_DATA / 8;
    localparam bit         DIRECT   = (RD_LATENCY == 1);
    localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY - 1);

    dmem_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [NB_DATA-1:0]  mem_data_q;
    logic                rd_valid_q;
    logic [NB_DATA-1:0]  dbg_data_q;
    logic                dbg_valid_q;
    logic                mis_q;
    logic                sucio_q;
    logic [LSB-1:0]      req_lane_q;
    logic [1:0]          req_size_q;
    logic                req_uns_q;

    logic [LSB-1:0]      lane;
    logic [NB_WADDR-1:0] word_idx;
    logic [1:0]          size;
    logic                is_wr, is_rd, is_uns;
    logic                idle, dbg_own, pipe_ok, req_mis;
    logic                store_acc, load_acc, mis_hit, dbg_wr, dbg_rd;
    logic                load_done, dbg_done;
    logic [NB_BYTES-1:0] be_base, store_be;
    logic [NB_DATA-1:0]  store_wdata;
    logic [LSB-1:0]      ext_lane;
    logic [1:0]          ext_size;
    logic                ext_uns;

    logic [NB_WADDR-1:0] bram_addr;
    logic [NB_BYTES-1:0] bram_we;
    logic [NB_DATA-1:0]  bram_wdata;
    logic [NB_DATA-1:0]  bram_rdata;

    logic ctrl_unused;
    assign ctrl_unused = ^i_MEM_control;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [LSB-1:0] ln);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return ln[0];
            SZ_WORD: return ln[1:0] != 2'b00;
            default: return ln != '0;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-fill above the access size.
    function automatic logic [NB_DATA-1:0] extend(input logic [NB_DATA-1:0] word,
                                                  input logic [1:0]         sz,
                                                  input logic [LSB-1:0]     ln,
                                                  input logic               uns);
        logic [NB_DATA-1:0] sh;
        logic [NB_DATA-1:0] mask;
        logic               sign;
        sh   = word >> {ln, 3'b000};
        mask = '1;
        sign = 1'b0;
        case (sz)
            SZ_BYTE: begin mask = NB_DATA'(8'hFF);         sign = sh[7];  end
            SZ_HALF: begin mask = NB_DATA'(16'hFFFF);      sign = sh[15]; end
            SZ_WORD: begin mask = NB_DATA'(32'hFFFF_FFFF); sign = sh[31]; end
            default: begin mask = '1;                      sign = 1'b0;   end
        endcase
        return (sh & mask) | ((!uns && sign) ? ~mask : '0);
    endfunction

    assign lane     = i_alu_result[LSB-1:0];
    assign word_idx = i_alu_result[ADDRWIDTH-1:LSB];
    assign size     = i_MEM_control[SIZE_MSB:SIZE_LSB];
    assign is_wr    = i_MEM_control[WRITE_BIT];
    assign is_rd    = i_MEM_control[READ_BIT] & ~is_wr;
    assign is_uns   = i_MEM_control[UNSIGNED_BIT];

    assign idle      = (state_q == IDLE);
    assign dbg_own   = idle & i_ctrl_addr_debug_mem;
    assign pipe_ok   = idle & ~i_ctrl_addr_debug_mem & i_enable_mem;
    assign req_mis   = is_misaligned(size, lane);
    assign store_acc = pipe_ok & is_wr & ~req_mis;
    assign load_acc  = pipe_ok & is_rd & ~req_mis;
    assign mis_hit   = pipe_ok & (is_wr | is_rd) & req_mis;
    assign dbg_wr    = dbg_own & i_ctrl_wr_debug_mem;
    assign dbg_rd    = dbg_own & ~i_ctrl_wr_debug_mem;

    always_comb begin
        be_base = '0;
        case (size)
            SZ_BYTE: be_base = NB_BYTES'(1);
            SZ_HALF: be_base = NB_BYTES'(3);
            SZ_WORD: be_base = NB_BYTES'(4'hF);
            default: be_base = '1;
        endcase
        store_be    = be_base << lane;
        store_wdata = i_data_write << {lane, 3'b000};
    end

    // Debug owns the array whenever it asks in IDLE, so the two sides never collide.
    assign bram_addr  = dbg_own ? i_addr_mem_debug_unit : word_idx;
    assign bram_we    = dbg_wr ? '1 : (store_acc ? store_be : '0);
    assign bram_wdata = dbg_wr ? i_data_debug_unit : store_wdata;

    dmem_bram #(
        .NB_DATA    (NB_DATA),
        .NB_WADDR   (NB_WADDR),
        .RD_LATENCY (RD_LATENCY)
    ) u_bram (
        .clk_i   (i_clock),
        .addr_i  (bram_addr),
        .we_i    (bram_we),
        .wdata_i (bram_wdata),
        .rdata_o (bram_rdata)
    );

    assign ext_lane = DIRECT ? lane   : req_lane_q;
    assign ext_size = DIRECT ? size   : req_size_q;
    assign ext_uns  = DIRECT ? is_uns : req_uns_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_done = 1'b0;
        dbg_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    if (DIRECT) begin
                        load_done = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 3'd1;
                    end
                end else if (dbg_rd) begin
                    if (DIRECT) begin
                        dbg_done = 1'b1;
                    end else begin
                        state_d = DBG_WAIT;
                        cnt_d   = 3'd1;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DBG_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    dbg_done = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
            mis_q       <= 1'b0;
            sucio_q     <= 1'b0;
            req_lane_q  <= '0;
            req_size_q  <= '0;
            req_uns_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_valid_q  <= load_done;
            dbg_valid_q <= dbg_done;
            mis_q       <= mis_hit;
            if (load_done) begin
                mem_data_q <= extend(bram_rdata, ext_size, ext_lane, ext_uns);
            end
            if (dbg_done) begin
                dbg_data_q <= bram_rdata;
            end
            if (load_acc) begin
                req_lane_q <= lane;
                req_size_q <= size;
                req_uns_q  <= is_uns;
            end
            if (store_acc) begin
                sucio_q <= 1'b1;
            end else if (i_clr_sucio) begin
                sucio_q <= 1'b0;
            end
        end
    end

    // Stall is combinational so the acceptance cycle itself already holds the pipeline.
    assign o_stall = i_reset & (load_acc | dbg_own | (state_q != IDLE));

    assign o_mem_data            = mem_data_q;
    assign o_rd_valid            = rd_valid_q;
    assign o_misaligned          = mis_q;
    assign o_bit_sucio           = sucio_q;
    assign o_data_mem_debug_unit = dbg_data_q;
    assign o_dbg_valid           = dbg_valid_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem: one instance at read latency 1, one at 3, sharing stimulus.
module tb_mem_stage_dmem;

    localparam logic [5:0] LD_B  = 6'h20;
    localparam logic [5:0] LD_BU = 6'h28;
    localparam logic [5:0] LD_H  = 6'h22;
    localparam logic [5:0] LD_HU = 6'h2A;
    localparam logic [5:0] LD_W  = 6'h24;
    localparam logic [5:0] LD_F  = 6'h26;
    localparam logic [5:0] ST_B  = 6'h10;
    localparam logic [5:0] ST_H  = 6'h12;
    localparam logic [5:0] ST_W  = 6'h14;
    localparam logic [5:0] ST_F  = 6'h16;
    localparam logic [5:0] RW_W  = 6'h34;

    typedef struct {
        logic        en;
        logic [5:0]  ctrl;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        expStall;
        logic        expValid;
        logic        expMis;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [5:0]  memCtrl;
    logic [9:0]  aluResult;
    logic [31:0] dataWrite;
    logic        clrSucio;
    logic        dbgSel;
    logic        dbgWr;
    logic [7:0]  dbgAddr;
    logic [31:0] dbgData;

    logic [31:0] memData1, dbgOut1, memData3, dbgOut3;
    logic        rdValid1, stall1, mis1, sucio1, dbgValid1;
    logic        rdValid3, stall3, mis3, sucio3, dbgValid3;

    mem_stage_dmem #(.NB_DATA(32), .ADDRWIDTH(10), .NB_MEM_CTRL(6), .RD_LATENCY(1)) dut1 (
        .i_clock(clock), .i_reset(reset), .i_enable_mem(enable), .i_MEM_control(memCtrl),
        .i_alu_result(aluResult), .i_data_write(dataWrite), .o_mem_data(memData1),
        .o_rd_valid(rdValid1), .o_stall(stall1), .o_misaligned(mis1), .o_bit_sucio(sucio1),
        .i_clr_sucio(clrSucio), .i_ctrl_addr_debug_mem(dbgSel), .i_ctrl_wr_debug_mem(dbgWr),
        .i_addr_mem_debug_unit(dbgAddr), .i_data_debug_unit(dbgData),
        .o_data_mem_debug_unit(dbgOut1), .o_dbg_valid(dbgValid1)
    );

    mem_stage_dmem #(.NB_DATA(32), .ADDRWIDTH(10), .NB_MEM_CTRL(6), .RD_LATENCY(3)) dut3 (
        .i_clock(clock), .i_reset(reset), .i_enable_mem(enable), .i_MEM_control(memCtrl),
        .i_alu_result(aluResult), .i_data_write(dataWrite), .o_mem_data(memData3),
        .o_rd_valid(rdValid3), .o_stall(stall3), .o_misaligned(mis3), .o_bit_sucio(sucio3),
        .i_clr_sucio(clrSucio), .i_ctrl_addr_debug_mem(dbgSel), .i_ctrl_wr_debug_mem(dbgWr),
        .i_addr_mem_debug_unit(dbgAddr), .i_data_debug_unit(dbgData),
        .o_data_mem_debug_unit(dbgOut3), .o_dbg_valid(dbgValid3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        enable    = 1'b1;
        memCtrl   = '0;
        aluResult = '0;
        dataWrite = '0;
    endtask

    task automatic applyStimulus(input logic en, input logic [5:0] ctrl,
                                 input logic [9:0] addr, input logic [31:0] wdata);
        enable    = en;
        memCtrl   = ctrl;
        aluResult = addr;
        dataWrite = wdata;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic en, input logic [5:0] ctrl, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic st, input logic va,
                          input logic mi, input logic [31:0] data);
        vecs.push_back('{en, ctrl, addr, wdata, st, va, mi, data});
    endtask

    // One pipeline load on the latency-1 instance, then enough idle cycles for the latency-3 one.
    task automatic pipeLoadCheck(input string name, input logic [5:0] ctrl,
                                 input logic [9:0] addr, input logic [31:0] expData);
        applyStimulus(1'b1, ctrl, addr, 32'h0);
        tick();
        idleInputs();
        checkOutput({name, " valid"}, {31'b0, rdValid1}, 32'd1);
        checkOutput({name, " data"}, memData1, expData);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawValid;

        reset    = 1'b0;
        clrSucio = 1'b0;
        dbgSel   = 1'b0;
        dbgWr    = 1'b0;
        dbgAddr  = '0;
        dbgData  = '0;
        idleInputs();
        #2;
        checkOutput("reset mem_data", memData1, 32'h0);
        checkOutput("reset rd_valid", {31'b0, rdValid1}, 32'd0);
        checkOutput("reset stall", {31'b0, stall1}, 32'd0);
        checkOutput("reset sucio", {31'b0, sucio1}, 32'd0);
        checkOutput("reset dbg_valid", {31'b0, dbgValid1}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        addVec(1, ST_W, 10'h000, 32'h12345678, 0, 0, 0, 32'h00000000);
        addVec(1, LD_W, 10'h000, 32'h0,        1, 1, 0, 32'h12345678);
        addVec(1, ST_W, 10'h004, 32'h11223344, 0, 0, 0, 32'h12345678);
        addVec(1, ST_B, 10'h005, 32'hCAFE00AB, 0, 0, 0, 32'h12345678);
        addVec(1, LD_B, 10'h005, 32'h0,        1, 1, 0, 32'hFFFFFFAB);
        addVec(1, LD_HU,10'h004, 32'h0,        1, 1, 0, 32'h0000AB44);
        addVec(1, LD_W, 10'h004, 32'h0,        1, 1, 0, 32'h1122AB44);
        addVec(1, LD_H, 10'h003, 32'h0,        0, 0, 1, 32'h1122AB44);
        addVec(1, ST_W, 10'h002, 32'hDEADDEAD, 0, 0, 1, 32'h1122AB44);
        addVec(1, LD_W, 10'h000, 32'h0,        1, 1, 0, 32'h12345678);
        addVec(1, LD_BU,10'h007, 32'h0,        1, 1, 0, 32'h00000011);
        addVec(1, ST_H, 10'h006, 32'h00008001, 0, 0, 0, 32'h00000011);
        addVec(1, LD_H, 10'h006, 32'h0,        1, 1, 0, 32'hFFFF8001);
        addVec(1, LD_HU,10'h006, 32'h0,        1, 1, 0, 32'h00008001);
        addVec(1, LD_B, 10'h004, 32'h0,        1, 1, 0, 32'h00000044);
        addVec(1, RW_W, 10'h008, 32'hA5A5A5A5, 0, 0, 0, 32'h00000044);
        addVec(1, LD_W, 10'h008, 32'h0,        1, 1, 0, 32'hA5A5A5A5);
        addVec(0, LD_W, 10'h000, 32'h0,        0, 0, 0, 32'hA5A5A5A5);
        addVec(1, LD_F, 10'h001, 32'h0,        0, 0, 1, 32'hA5A5A5A5);
        addVec(1, ST_F, 10'h00C, 32'h87654321, 0, 0, 0, 32'hA5A5A5A5);
        addVec(1, LD_W, 10'h00C, 32'h0,        1, 1, 0, 32'h87654321);
        addVec(1, LD_F, 10'h00C, 32'h0,        1, 1, 0, 32'h87654321);
        addVec(1, LD_B, 10'h00F, 32'h0,        1, 1, 0, 32'hFFFFFF87);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("v%0d stall", i), {31'b0, stall1}, {31'b0, vecs[i].expStall});
            tick();
            idleInputs();
            checkOutput($sformatf("v%0d rd_valid", i), {31'b0, rdValid1}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("v%0d misaligned", i), {31'b0, mis1}, {31'b0, vecs[i].expMis});
            checkOutput($sformatf("v%0d mem_data", i), memData1, vecs[i].expData);
            repeat (3) tick();
        end

        checkOutput("sucio after stores", {31'b0, sucio1}, 32'd1);
        clrSucio = 1'b1;
        tick();
        clrSucio = 1'b0;
        checkOutput("sucio cleared", {31'b0, sucio1}, 32'd0);
        repeat (3) tick();

        // Debug write while the pipeline tries a store that must be ignored.
        dbgSel  = 1'b1;
        dbgWr   = 1'b1;
        dbgAddr = 8'd7;
        dbgData = 32'hDEADBEEF;
        applyStimulus(1'b1, ST_W, 10'h000, 32'hFFFFFFFF);
        checkOutput("dbg write stall", {31'b0, stall1}, 32'd1);
        tick();
        idleInputs();
        dbgWr = 1'b0;
        tick();
        checkOutput("dbg read valid", {31'b0, dbgValid1}, 32'd1);
        checkOutput("dbg read data", dbgOut1, 32'hDEADBEEF);
        dbgSel = 1'b0;
        checkOutput("sucio after dbg write", {31'b0, sucio1}, 32'd0);
        repeat (4) tick();

        pipeLoadCheck("word0 kept", LD_W, 10'h000, 32'h12345678);
        pipeLoadCheck("dbg word via pipe", LD_W, 10'h01C, 32'hDEADBEEF);

        clrSucio = 1'b1;
        applyStimulus(1'b1, ST_W, 10'h020, 32'h0BADF00D);
        tick();
        clrSucio = 1'b0;
        idleInputs();
        checkOutput("sucio set beats clear", {31'b0, sucio1}, 32'd1);
        repeat (3) tick();

        // Latency 3: debug arrives during RD_WAIT and is served after the load.
        applyStimulus(1'b1, LD_W, 10'h020, 32'h0);
        checkOutput("L3 accept stall", {31'b0, stall3}, 32'd1);
        tick();
        idleInputs();
        dbgSel  = 1'b1;
        dbgWr   = 1'b0;
        dbgAddr = 8'd7;
        #1;
        checkOutput("L3 c1 stall", {31'b0, stall3}, 32'd1);
        checkOutput("L3 c1 rd_valid", {31'b0, rdValid3}, 32'd0);
        tick();
        checkOutput("L3 c2 rd_valid", {31'b0, rdValid3}, 32'd0);
        tick();
        checkOutput("L3 c3 rd_valid", {31'b0, rdValid3}, 32'd1);
        checkOutput("L3 c3 mem_data", memData3, 32'h0BADF00D);
        tick();
        dbgSel = 1'b0;
        checkOutput("L3 c4 dbg_valid", {31'b0, dbgValid3}, 32'd0);
        tick();
        checkOutput("L3 c5 dbg_valid", {31'b0, dbgValid3}, 32'd0);
        tick();
        checkOutput("L3 c6 dbg_valid", {31'b0, dbgValid3}, 32'd1);
        checkOutput("L3 c6 dbg_data", dbgOut3, 32'hDEADBEEF);
        repeat (4) tick();

        // Reset during RD_WAIT aborts the load but keeps the array.
        applyStimulus(1'b1, LD_W, 10'h020, 32'h0);
        tick();
        idleInputs();
        reset = 1'b0;
        #1;
        checkOutput("rst mid-read stall", {31'b0, stall3}, 32'd0);
        checkOutput("rst mid-read rd_valid", {31'b0, rdValid3}, 32'd0);
        checkOutput("rst mid-read mem_data", memData3, 32'h0);
        checkOutput("rst sucio", {31'b0, sucio1}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        sawValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rdValid3) sawValid = 1'b1;
        end
        checkOutput("aborted read no valid", {31'b0, sawValid}, 32'd0);
        applyStimulus(1'b1, LD_W, 10'h020, 32'h0);
        tick();
        idleInputs();
        tick();
        tick();
        checkOutput("post-reset L3 valid", {31'b0, rdValid3}, 32'd1);
        checkOutput("post-reset L3 data", memData3, 32'h0BADF00D);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
